// File: rtl/countdown_timer_bcd_if.sv
// Control and display bundle for the BCD countdown timer.
// The master side (controller or bench) drives load/start/pause and the
// preset digits; the slave side (timer core) drives the four display
// digits and the running/done status levels.
interface countdown_timer_bcd_if;

  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] preset_m10;
  logic [3:0] preset_m1;
  logic [3:0] preset_s10;
  logic [3:0] preset_s1;

  logic [3:0] m10;
  logic [3:0] m1;
  logic [3:0] s10;
  logic [3:0] s1;
  logic       running;
  logic       done;

  modport master (
    output load, start, pause,
    output preset_m10, preset_m1, preset_s10, preset_s1,
    input  m10, m1, s10, s1, running, done
  );

  modport slave (
    input  load, start, pause,
    input  preset_m10, preset_m1, preset_s10, preset_s1,
    output m10, m1, s10, s1, running, done
  );

endinterface

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer. Loads a clamped preset, decrements once per
// TICK_DIV clock cycles through a mod-10/mod-6/mod-10/mod-10 borrow chain,
// and parks in DONE at 00:00. The count never wraps below zero.
module countdown_timer_bcd #(
  parameter int TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_timer_bcd_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Four BCD digits packed as {m10, m1, s10, s1}.
  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } count_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  count_t          count_q, count_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            tick;
  logic            count_zero;

  // Clamp out-of-range preset digits: units/minutes to 9, seconds-tens to 5.
  function automatic count_t clamp_preset(input logic [3:0] pm10, input logic [3:0] pm1,
                                          input logic [3:0] ps10, input logic [3:0] ps1);
    count_t c;
    c.m10 = (pm10 > 4'd9) ? 4'd9 : pm10;
    c.m1  = (pm1  > 4'd9) ? 4'd9 : pm1;
    c.s10 = (ps10 > 4'd5) ? 4'd5 : ps10;
    c.s1  = (ps1  > 4'd9) ? 4'd9 : ps1;
    return c;
  endfunction

  // One-second decrement with borrow rippling s1 -> s10 -> m1 -> m10.
  // Callers never pass 00:00, so m10 is non-zero whenever it is reached.
  function automatic count_t bcd_decrement(input count_t v);
    count_t c;
    c = v;
    if (c.s1 == 4'd0) begin
      c.s1 = 4'd9;
      if (c.s10 == 4'd0) begin
        c.s10 = 4'd5;
        if (c.m1 == 4'd0) begin
          c.m1  = 4'd9;
          c.m10 = c.m10 - 4'd1;
        end else begin
          c.m1 = c.m1 - 4'd1;
        end
      end else begin
        c.s10 = c.s10 - 4'd1;
      end
    end else begin
      c.s1 = c.s1 - 4'd1;
    end
    return c;
  endfunction

  assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign count_zero = (count_q == '0);

  // Next-state, prescaler and count update; load overrides everything else.
  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;

    if (bus.load) begin
      count_d = clamp_preset(bus.preset_m10, bus.preset_m1,
                             bus.preset_s10, bus.preset_s1);
      presc_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (bus.pause) begin
            state_d = PAUSED;
          end
          if (tick) begin
            count_d = bcd_decrement(count_q);
            // Reaching 00:00 ends the run even if pause arrived this edge.
            if (count_d == '0) begin
              state_d = DONE;
            end
          end
        end
        IDLE, PAUSED: begin
          // pause outranks start, and pause itself does nothing here.
          if (bus.start && !bus.pause) begin
            if (count_zero) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              // Resuming keeps the partial prescaler count; a fresh start
              // restarts the full tick period.
              if (state_q == IDLE) begin
                presc_d = '0;
              end
            end
          end
        end
        DONE: begin
          // Holds 00:00 until a load.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, prescaler, digits and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.m10     = count_q.m10;
  assign bus.m1      = count_q.m1;
  assign bus.s10     = count_q.s10;
  assign bus.s1      = count_q.s1;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule
